instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
Inverse of the core's instruction decoder. Accepts symbolic operation requests (op, rd, rs1, rs2, imm) over a valid/ready handshake and encodes each into a 32-bit RV32I instruction word. Valid words are buffered in a small FIFO and streamed out with a sequential instruction-memory address. A session FSM (start … last) brackets each program load for boot/test program loading.

Parameters:
DEPTH, 4, output FIFO depth in words (power of two, ≥2)
ADDR_W, 32, width of out_addr
BASE_ADDR, 0, address of first word after start
ADDR_STEP, 4, address increment per emitted word

Ports:
clk  in  1  system clock
rst_n  in  1  reset
start  in  1  pulse: open a load session, reset address to BASE_ADDR
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid&ready
req_op  in  5  operation code, from the shared enum
req_rd  in  5  destination register
req_rs1  in  5  source register 1
req_rs2  in  5  source register 2
req_imm  in  32  signed immediate (LUI: value for imm[31:12], taken from req_imm[19:0])
req_last  in  1  final request of session
out_valid  out  1  encoded word available
out_ready  in  1  sink accepts word
out_instr  out  32  encoded instruction
out_addr  out  ADDR_W  target address of out_instr
busy  out  1  FSM not IDLE
done  out  1  one-cycle pulse at end of session
err_illegal  out  1  sticky: a request was rejected

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. FSM=IDLE, FIFO empty, address=BASE_ADDR. All outputs are 0, except out_addr=BASE_ADDR.
- FSM states IDLE→LOAD on start. LOAD→DRAIN on an accepted request with req_last=1. DRAIN→IDLE when the FIFO is empty; done pulses high for 1 cycle on that transition. start is ignored outside IDLE.
- req_ready = (state==LOAD) && FIFO not full. Requests outside LOAD are not accepted.
- Encoding is combinational from the request fields; the word is written to the FIFO in the accept cycle. Latency is 1 cycle from accept to out_valid when the FIFO was empty.
- R-type (ADD, SUB, XOR, OR, AND, SLT):
  - opcode 0110011.
  - funct3: 000/000/100/110/111/010.
  - funct7: 0100000 for SUB, else 0.
- I-type (ADDI, XORI, ORI, ANDI):
  - opcode 0010011, funct3 000/100/110/111.
  - imm[11:0] in bits 31:20.
- LW: opcode 0000011, funct3 010, I-format.
- SW: opcode 0100011, funct3 010, imm[11:5]→31:25, imm[4:0]→11:7.
- LUI: opcode 0110111, req_imm[19:0]→31:12.
- BEQ/BNE/BLT/BGE:
  - opcode 1100011, funct3 000/001/100/101.
  - Bit placement: imm[12]→31, imm[10:5]→30:25, imm[4:1]→11:8, imm[11]→7.
- Register fields not used by a format are encoded as 0.
- Illegal request: unknown op; I/S imm outside −2048..2047; B imm outside −4096..4094 or odd. The request is still accepted (consumed) but no word is written, the address does not advance, and err_illegal sets. An illegal request with req_last still ends LOAD.
- err_illegal clears only on start or reset.
- Output side:
  - out_instr/out_addr show the FIFO head while out_valid=1.
  - On out_valid&out_ready, pop the head and advance the address by ADDR_STEP, wrapping modulo 2^ADDR_W.
  - The address is bound at pop, so out_addr is stable while stalled.
- Simultaneous push and pop when full: push is not allowed (ready=0). When empty, a push is visible only next cycle (no bypass).
- Reset mid-session discards FIFO contents and returns to IDLE with no done pulse.

Decomposition:
- Shared package `rv_enc_pkg`:
  - op enum: ADD=0, SUB, XOR, OR, AND, SLT, ADDI, XORI, ORI, ANDI, LW, SW, LUI, BEQ, BNE, BLT, BGE=16.
  - 7-bit opcode constants (R, I, LOAD, STORE, LUI, BRANCH), funct3 constants, FUNCT7_SUB.
  - Immediate range limits.
- Sub-module `instr_fifo`: synchronous FIFO of DEPTH×32, with full/empty flags and pointer wrap.

Test Plan:
- start; ADD rd=3 rs1=1 rs2=2, last → out_instr 0x002081B3 @ out_addr 0x0; done pulses after the pop; busy falls.
- start; SUB 5,6,7; ADDI rd=1 rs1=0 imm=−1; LUI rd=5 imm=0x12345 (last) → 0x407302B3 @0, 0xFFF00093 @4, 0x123452B7 @8.
- SW rs1=1 rs2=2 imm=8 → 0x0020A423. BEQ rs1=1 rs2=2 imm=−4 → 0xFE208EE3.
- Hold out_ready=0 with DEPTH=4 and issue 6 requests → req_ready=0 after 4 accepts. Release → words drain in order with addresses 0,4,8,…,20 and no loss.
- ADDI imm=2048, then BEQ imm=3 → neither emitted, address unchanged, err_illegal=1 until the next start.
- Assert rst_n low mid-LOAD with 2 words buffered → out_valid=0, busy=0, out_addr=BASE_ADDR immediately; no done pulse.

Source files
------------

// File: rtl/rv_enc_pkg.sv
// Shared RV32I encoding definitions: symbolic op codes, opcode/funct fields,
// immediate range limits and the combinational request-to-word encoder.
package rv_enc_pkg;

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,
    OP_SUB  = 5'd1,
    OP_XOR  = 5'd2,
    OP_OR   = 5'd3,
    OP_AND  = 5'd4,
    OP_SLT  = 5'd5,
    OP_ADDI = 5'd6,
    OP_XORI = 5'd7,
    OP_ORI  = 5'd8,
    OP_ANDI = 5'd9,
    OP_LW   = 5'd10,
    OP_SW   = 5'd11,
    OP_LUI  = 5'd12,
    OP_BEQ  = 5'd13,
    OP_BNE  = 5'd14,
    OP_BLT  = 5'd15,
    OP_BGE  = 5'd16
  } op_e;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

  localparam logic [6:0] FUNCT7_SUB = 7'b0100000;

  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int IMMB_MIN  = -4096;
  localparam int IMMB_MAX  = 4094;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_U, FMT_B, FMT_BAD} fmt_e;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DRAIN} state_e;

  typedef struct packed {
    logic        legal;
    logic [31:0] word;
  } enc_t;

  function automatic enc_t encode(input logic [4:0] op, input logic [4:0] rd,
                                  input logic [4:0] rs1, input logic [4:0] rs2,
                                  input logic [31:0] imm);
    enc_t              r;
    fmt_e              fmt;
    logic [6:0]        opc;
    logic [6:0]        f7;
    logic [2:0]        f3;
    logic signed [31:0] s;
    logic              imm12_ok;
    logic              immb_ok;
    s        = imm;
    imm12_ok = (s >= IMM12_MIN) && (s <= IMM12_MAX);
    immb_ok  = (s >= IMMB_MIN) && (s <= IMMB_MAX) && !imm[0];
    fmt = FMT_BAD;
    opc = '0;
    f3  = '0;
    f7  = '0;
    case (op)
      OP_ADD:  begin fmt = FMT_R; opc = OPC_R; f3 = F3_ADD; end
      OP_SUB:  begin fmt = FMT_R; opc = OPC_R; f3 = F3_ADD; f7 = FUNCT7_SUB; end
      OP_XOR:  begin fmt = FMT_R; opc = OPC_R; f3 = F3_XOR; end
      OP_OR:   begin fmt = FMT_R; opc = OPC_R; f3 = F3_OR;  end
      OP_AND:  begin fmt = FMT_R; opc = OPC_R; f3 = F3_AND; end
      OP_SLT:  begin fmt = FMT_R; opc = OPC_R; f3 = F3_SLT; end
      OP_ADDI: begin fmt = FMT_I; opc = OPC_I; f3 = F3_ADD; end
      OP_XORI: begin fmt = FMT_I; opc = OPC_I; f3 = F3_XOR; end
      OP_ORI:  begin fmt = FMT_I; opc = OPC_I; f3 = F3_OR;  end
      OP_ANDI: begin fmt = FMT_I; opc = OPC_I; f3 = F3_AND; end
      OP_LW:   begin fmt = FMT_I; opc = OPC_LOAD;  f3 = F3_LW; end
      OP_SW:   begin fmt = FMT_S; opc = OPC_STORE; f3 = F3_SW; end
      OP_LUI:  begin fmt = FMT_U; opc = OPC_LUI; end
      OP_BEQ:  begin fmt = FMT_B; opc = OPC_BRANCH; f3 = F3_BEQ; end
      OP_BNE:  begin fmt = FMT_B; opc = OPC_BRANCH; f3 = F3_BNE; end
      OP_BLT:  begin fmt = FMT_B; opc = OPC_BRANCH; f3 = F3_BLT; end
      OP_BGE:  begin fmt = FMT_B; opc = OPC_BRANCH; f3 = F3_BGE; end
      default: ;
    endcase
    // register fields a format does not use are left at zero
    r = '0;
    case (fmt)
      FMT_R: begin r.legal = 1'b1;     r.word = {f7, rs2, rs1, f3, rd, opc}; end
      FMT_I: begin r.legal = imm12_ok; r.word = {imm[11:0], rs1, f3, rd, opc}; end
      FMT_S: begin r.legal = imm12_ok; r.word = {imm[11:5], rs2, rs1, f3, imm[4:0], opc}; end
      FMT_U: begin r.legal = 1'b1;     r.word = {imm[19:0], rd, opc}; end
      FMT_B: begin
        r.legal = immb_ok;
        r.word  = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
      end
      default: ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request and instruction-stream handshake bundle of the instruction encoder.
// master drives requests and accepts words; slave is the encoder view.
interface instr_encoder_if #(
  parameter int ADDR_W = 32
) ();
  logic              req_valid;
  logic              req_ready;
  logic [4:0]        req_op;
  logic [4:0]        req_rd;
  logic [4:0]        req_rs1;
  logic [4:0]        req_rs2;
  logic [31:0]       req_imm;
  logic              req_last;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;

  modport master (
    output req_valid, req_op, req_rd, req_rs1, req_rs2, req_imm, req_last, out_ready,
    input  req_ready, out_valid, out_instr, out_addr
  );

  modport slave (
    input  req_valid, req_op, req_rd, req_rs1, req_rs2, req_imm, req_last, out_ready,
    output req_ready, out_valid, out_instr, out_addr
  );
endinterface

// File: rtl/instr_fifo.sv
// Synchronous word FIFO with wrap-bit pointers; head is read combinationally,
// so a push becomes visible on the cycle after it is written.
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;

  always_ff @(posedge clk) begin
    if (push && !full) mem[wptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) wptr <= wptr + (AW+1)'(1);
      if (pop && !empty) rptr <= rptr + (AW+1)'(1);
    end
  end

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rdata = mem[rptr[AW-1:0]];
endmodule

// File: rtl/instr_encoder.sv
// Encodes symbolic RV32I requests into instruction words, buffers them and
// streams them out with sequential load addresses inside a start..last session.
//   state    | meaning
//   ST_IDLE  | no session; waiting for start
//   ST_LOAD  | accepting requests until one with req_last
//   ST_DRAIN | no more requests; emptying the FIFO, done on empty
module instr_encoder
  import rv_enc_pkg::*;
#(
  parameter int                DEPTH     = 4,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  instr_encoder_if.slave  bus,
  output logic            busy,
  output logic            done,
  output logic            err_illegal
);
  state_e            state;
  state_e            state_nxt;
  enc_t              enc;
  logic              accept;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic              open_session;
  logic [31:0]       head;
  logic [ADDR_W-1:0] addr;

  assign enc = encode(bus.req_op, bus.req_rd, bus.req_rs1, bus.req_rs2, bus.req_imm);

  assign bus.req_ready = (state == ST_LOAD) && !full;
  assign accept        = bus.req_valid && bus.req_ready;
  // illegal requests are consumed but never reach the FIFO
  assign push          = accept && enc.legal;
  assign pop           = !empty && bus.out_ready;
  assign open_session  = (state == ST_IDLE) && start;

  instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (enc.word),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_LOAD;
      ST_LOAD:  if (accept && bus.req_last) state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (empty) begin
          state_nxt = ST_IDLE;
          done      = 1'b1;
        end
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);

  // address is bound to the head word and only moves when that word leaves
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            addr <= BASE_ADDR;
    else if (open_session) addr <= BASE_ADDR;
    else if (pop)          addr <= addr + ADDR_STEP;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    err_illegal <= 1'b0;
    else if (open_session)         err_illegal <= 1'b0;
    else if (accept && !enc.legal) err_illegal <= 1'b1;
  end

  assign bus.out_valid = !empty;
  assign bus.out_instr = head;
  assign bus.out_addr  = addr;
endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: single-request vector table plus
// hand-written multi-word, backpressure, illegal-request and reset sequences.
module tb_instr_encoder;
  import rv_enc_pkg::*;

  logic clk;
  logic rst_n;
  logic start;
  logic busy;
  logic done;
  logic err_illegal;
  int   checks;
  int   errors;

  instr_encoder_if #(.ADDR_W(32)) bus ();

  instr_encoder #(
    .DEPTH     (4),
    .ADDR_W    (32),
    .BASE_ADDR (32'h0),
    .ADDR_STEP (32'd4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .bus         (bus),
    .busy        (busy),
    .done        (done),
    .err_illegal (err_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        legal;
    logic [31:0] word;
    string       name;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [31:0] imm, input logic legal,
                              input logic [31:0] word, input string name);
    vec_t v;
    v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
    v.legal = legal; v.word = word; v.name = name;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm, input logic last);
    int n;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_rd    = rd;
    bus.req_rs1   = rs1;
    bus.req_rs2   = rs2;
    bus.req_imm   = imm;
    bus.req_last  = last;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      tick();
      n++;
    end
    chk("send_ready", 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = 1'b0;
    bus.req_last  = 1'b0;
  endtask

  task automatic expect_word(input string name, input logic [31:0] word, input logic [31:0] addr);
    int n;
    n = 0;
    while (!bus.out_valid && n < 50) begin
      tick();
      n++;
    end
    chk({name, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({name, "_instr"}, bus.out_instr, word);
    chk({name, "_addr"}, bus.out_addr, addr);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 50) begin
      tick();
      n++;
    end
    chk({name, "_done"}, 32'(done), 32'd1);
    tick();
    chk({name, "_done_pulse"}, 32'(done), 32'd0);
    chk({name, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_rd    = '0;
    bus.req_rs1   = '0;
    bus.req_rs2   = '0;
    bus.req_imm   = '0;
    bus.req_last  = 1'b0;
    bus.out_ready = 1'b0;

    vecs.push_back(mk(OP_ADD,  3, 1, 2, 32'd0,        1'b1, 32'h002081B3, "add"));
    vecs.push_back(mk(OP_SUB,  5, 6, 7, 32'd0,        1'b1, 32'h407302B3, "sub"));
    vecs.push_back(mk(OP_XOR,  4, 5, 6, 32'd0,        1'b1, 32'h0062C233, "xor"));
    vecs.push_back(mk(OP_SLT,  1, 2, 3, 32'd0,        1'b1, 32'h003120B3, "slt"));
    vecs.push_back(mk(OP_ADDI, 1, 0, 9, 32'hFFFFFFFF, 1'b1, 32'hFFF00093, "addi_m1"));
    vecs.push_back(mk(OP_ADDI, 2, 0, 0, -32'sd2048,   1'b1, 32'h80000113, "addi_min"));
    vecs.push_back(mk(OP_ANDI, 9, 10, 0, 32'd2047,    1'b1, 32'h7FF57493, "andi_max"));
    vecs.push_back(mk(OP_LW,   7, 2, 0, -32'sd8,      1'b1, 32'hFF812383, "lw"));
    vecs.push_back(mk(OP_SW,  31, 1, 2, 32'd8,        1'b1, 32'h0020A423, "sw"));
    vecs.push_back(mk(OP_LUI,  5, 3, 4, 32'hFFF12345, 1'b1, 32'h123452B7, "lui"));
    vecs.push_back(mk(OP_BEQ,  9, 1, 2, -32'sd4,      1'b1, 32'hFE208EE3, "beq"));
    vecs.push_back(mk(OP_BGE,  0, 3, 4, 32'd4094,     1'b1, 32'h7E41DFE3, "bge_max"));
    vecs.push_back(mk(OP_BNE,  0, 5, 6, -32'sd4096,   1'b1, 32'h80629063, "bne_min"));
    vecs.push_back(mk(OP_ADDI, 1, 0, 0, 32'd2048,     1'b0, 32'h0,        "addi_2048"));
    vecs.push_back(mk(OP_BEQ,  0, 1, 2, 32'd3,        1'b0, 32'h0,        "beq_odd"));
    vecs.push_back(mk(5'd17,   1, 1, 1, 32'd0,        1'b0, 32'h0,        "op_unknown"));
    vecs.push_back(mk(OP_SW,   0, 1, 2, -32'sd2049,   1'b0, 32'h0,        "sw_low"));
    vecs.push_back(mk(OP_BLT,  0, 1, 2, 32'd4096,     1'b0, 32'h0,        "blt_high"));
    vecs.push_back(mk(OP_LW,   1, 1, 0, 32'd5000,     1'b0, 32'h0,        "lw_high"));

    tick();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err_illegal), 32'd0);
    chk("rst_addr", bus.out_addr, 32'h0);
    rst_n = 1'b1;
    tick();
    chk("idle_req_ready", 32'(bus.req_ready), 32'd0);

    // one session per vector
    foreach (vecs[i]) begin
      do_start();
      chk({vecs[i].name, "_busy"}, 32'(busy), 32'd1);
      chk({vecs[i].name, "_err_clr"}, 32'(err_illegal), 32'd0);
      send(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm, 1'b1);
      if (vecs[i].legal) begin
        expect_word(vecs[i].name, vecs[i].word, 32'h0);
      end else begin
        chk({vecs[i].name, "_err"}, 32'(err_illegal), 32'd1);
        chk({vecs[i].name, "_no_word"}, 32'(bus.out_valid), 32'd0);
      end
      wait_done(vecs[i].name);
      chk({vecs[i].name, "_err_hold"}, 32'(err_illegal), 32'(!vecs[i].legal));
    end

    // three-word session, start ignored while draining
    do_start();
    chk("seq_empty", 32'(bus.out_valid), 32'd0);
    send(OP_SUB, 5, 6, 7, 32'd0, 1'b0);
    chk("seq_latency", 32'(bus.out_valid), 32'd1);
    send(OP_ADDI, 1, 0, 0, 32'hFFFFFFFF, 1'b0);
    send(OP_LUI, 5, 0, 0, 32'h00012345, 1'b1);
    expect_word("seq_w0", 32'h407302B3, 32'h0);
    do_start();
    chk("seq_start_ign_busy", 32'(busy), 32'd1);
    chk("seq_no_early_done", 32'(done), 32'd0);
    expect_word("seq_w1", 32'hFFF00093, 32'h4);
    expect_word("seq_w2", 32'h123452B7, 32'h8);
    wait_done("seq");

    // backpressure: fill, stall, then drain six words in order
    do_start();
    for (int k = 0; k < 4; k++) send(OP_ADDI, 5'(k), 0, 0, 32'(k), 1'b0);
    chk("bp_full_ready", 32'(bus.req_ready), 32'd0);
    bus.req_valid = 1'b1;
    bus.req_op    = OP_ADDI;
    bus.req_rd    = 5'd4;
    bus.req_rs1   = 5'd0;
    bus.req_rs2   = 5'd0;
    bus.req_imm   = 32'd4;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_stall_ready", 32'(bus.req_ready), 32'd0);
      chk("bp_stall_addr", bus.out_addr, 32'h0);
      chk("bp_stall_instr", bus.out_instr, 32'h00000013);
    end
    fork
      begin
        send(OP_ADDI, 5'd4, 0, 0, 32'd4, 1'b0);
        send(OP_ADDI, 5'd5, 0, 0, 32'd5, 1'b1);
      end
      begin
        bus.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
          int n;
          n = 0;
          while (!bus.out_valid && n < 50) begin
            tick();
            n++;
          end
          chk("bp_valid", 32'(bus.out_valid), 32'd1);
          chk("bp_instr", bus.out_instr, (32'(k) << 20) | (32'(k) << 7) | 32'h13);
          chk("bp_addr", bus.out_addr, 32'(4 * k));
          tick();
        end
        bus.out_ready = 1'b0;
      end
    join
    wait_done("bp");

    // illegal requests interleaved with a legal one
    do_start();
    send(OP_ADDI, 1, 0, 0, 32'd2048, 1'b0);
    chk("ill_err", 32'(err_illegal), 32'd1);
    chk("ill_no_word", 32'(bus.out_valid), 32'd0);
    send(OP_ADD, 3, 1, 2, 32'd0, 1'b0);
    send(OP_BEQ, 0, 1, 2, 32'd3, 1'b1);
    expect_word("ill_add", 32'h002081B3, 32'h0);
    chk("ill_only_one", 32'(bus.out_valid), 32'd0);
    wait_done("ill");
    chk("ill_err_sticky", 32'(err_illegal), 32'd1);
    do_start();
    chk("ill_err_cleared", 32'(err_illegal), 32'd0);
    send(OP_ADD, 3, 1, 2, 32'd0, 1'b1);
    expect_word("ill_next", 32'h002081B3, 32'h0);
    wait_done("ill_next");

    // reset in the middle of LOAD with two words buffered
    do_start();
    send(OP_ADD, 3, 1, 2, 32'd0, 1'b0);
    send(OP_SUB, 5, 6, 7, 32'd0, 1'b0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("mr_addr_before", bus.out_addr, 32'h4);
    rst_n = 1'b0;
    #1;
    chk("mr_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_addr", bus.out_addr, 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("mr_no_done", 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    tick();
    chk("mr_idle_busy", 32'(busy), 32'd0);
    chk("mr_idle_valid", 32'(bus.out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
